link_tx_on_off: RTL and testbench

//  Upstream (transmit) end of the router-to-router flit link with on/off flow control.
//  - Sits at a router output port, between the crossbar and the link to the neighbour's input circular buffer.
//  - Queues flits from the crossbar and drives them onto the link only while the downstream buffer's on/off signal is ON.
//  - Tracks packet framing and counts sent flits and stall cycles.

---
 rtl/link_tx_on_off_pkg.sv | 21 ++
 rtl/link_tx_on_off_if.sv | 16 +
 rtl/tx_flit_queue.sv | 53 +++++
 rtl/link_tx_on_off.sv | 81 ++++++++
 tb/tb_link_tx_on_off.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/link_tx_on_off_pkg.sv
// Shared flit types and the transmit packet-framing state for the on/off link TX.
package link_tx_on_off_pkg;
  localparam int FLIT_DATA_W = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t             flit_label;
    logic [FLIT_DATA_W-1:0]  data;
  } flit_Data_noVC;

  typedef enum logic {
    TX_IDLE   = 1'b0,
    TX_IN_PKT = 1'b1
  } tx_state_t;
endpackage

// File: rtl/link_tx_on_off_if.sv
// Crossbar-side handshake plus link-side flit/valid and the downstream on/off line.
interface link_tx_on_off_if;
  import link_tx_on_off_pkg::*;

  flit_Data_noVC flit_i;
  logic          valid_i;
  logic          ready_o;
  logic          on_off_i;
  flit_Data_noVC link_flit_o;
  logic          link_valid_o;

  modport master (output flit_i, valid_i, on_off_i,
                  input  ready_o, link_flit_o, link_valid_o);
  modport slave  (input  flit_i, valid_i, on_off_i,
                  output ready_o, link_flit_o, link_valid_o);
endinterface

// File: rtl/tx_flit_queue.sv
// Small flit FIFO; full/empty are registered so ready depends only on state.
module tx_flit_queue
  import link_tx_on_off_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  flit_Data_noVC wdata_i,
  input  logic          pop_i,
  output flit_Data_noVC head_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = $clog2(DEPTH);

  flit_Data_noVC mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) wr_q <= (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      if (pop_i)  rd_q <= (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (PW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/link_tx_on_off.sv
// Router output-port link transmitter: queues crossbar flits and sends them while downstream is ON.
module link_tx_on_off
  import link_tx_on_off_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  link_tx_on_off_if.slave  bus,
  output logic             protocol_err_o,
  output logic [CNT_W-1:0] flits_sent_o,
  output logic [CNT_W-1:0] stall_cycles_o
);
  logic          full, empty, push, send, on_off_q;
  flit_Data_noVC head;
  tx_state_t     state_q;
  logic          lvalid_q, err_q;
  flit_Data_noVC lflit_q;
  logic [CNT_W-1:0] sent_q, stall_q;

  assign push = bus.valid_i & ~full;
  assign send = ~empty & on_off_q;

  tx_flit_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (bus.flit_i),
    .pop_i   (send),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_off_q <= 1'b1;
      state_q  <= TX_IDLE;
      lvalid_q <= 1'b0;
      lflit_q  <= '0;
      err_q    <= 1'b0;
      sent_q   <= '0;
      stall_q  <= '0;
    end else begin
      on_off_q <= bus.on_off_i;
      lvalid_q <= send;
      if (send) begin
        lflit_q <= head;
        if (sent_q != '1) sent_q <= sent_q + 1'b1;
        // Framing errors are flagged but the flit still goes out.
        case (head.flit_label)
          HEAD: begin
            if (state_q == TX_IN_PKT) err_q <= 1'b1;
            state_q <= TX_IN_PKT;
          end
          HEADTAIL: begin
            if (state_q == TX_IN_PKT) err_q <= 1'b1;
            state_q <= TX_IDLE;
          end
          BODY: begin
            if (state_q == TX_IDLE) err_q <= 1'b1;
          end
          TAIL: begin
            if (state_q == TX_IDLE) err_q <= 1'b1;
            state_q <= TX_IDLE;
          end
          default: ;
        endcase
      end
      if (!empty && !on_off_q && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.ready_o      = ~full;
  assign bus.link_valid_o = lvalid_q;
  assign bus.link_flit_o  = lflit_q;
  assign protocol_err_o   = err_q;
  assign flits_sent_o     = sent_q;
  assign stall_cycles_o   = stall_q;
endmodule

// File: tb/tb_link_tx_on_off.sv
// Self-checking bench: vector table, directed corner sequences and a queue-based random model.
module tb_link_tx_on_off;
  import link_tx_on_off_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  link_tx_on_off_if bus();
  logic             err;
  logic [CNT_W-1:0] sent, stall;

  link_tx_on_off #(.QUEUE_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .protocol_err_o (err),
    .flits_sent_o   (sent),
    .stall_cycles_o (stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain queue plus the framing rules.
  flit_Data_noVC m_q[$];
  logic          m_onq, m_lv, m_err, m_inpkt;
  flit_Data_noVC m_lf;
  int            m_sent, m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic flit_Data_noVC mkf(input flit_label_t l, input logic [15:0] d);
    flit_Data_noVC f;
    f.flit_label = l;
    f.data       = d;
    return f;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_onq = 1'b1; m_lv = 1'b0; m_lf = '0; m_err = 1'b0; m_inpkt = 1'b0;
    m_sent = 0; m_stall = 0;
  endfunction

  function automatic void m_step(input logic v, input flit_Data_noVC f, input logic on);
    logic acc;
    flit_Data_noVC h;
    acc = v && (m_q.size() < DEPTH);
    if (m_q.size() > 0 && !m_onq && m_stall < CMAX) m_stall++;
    if (m_q.size() > 0 && m_onq) begin
      h = m_q.pop_front();
      m_lv = 1'b1;
      m_lf = h;
      if (m_sent < CMAX) m_sent++;
      case (h.flit_label)
        HEAD:     begin if (m_inpkt) m_err = 1'b1; m_inpkt = 1'b1; end
        HEADTAIL: begin if (m_inpkt) m_err = 1'b1; m_inpkt = 1'b0; end
        BODY:     begin if (!m_inpkt) m_err = 1'b1; end
        default:  begin if (!m_inpkt) m_err = 1'b1; m_inpkt = 1'b0; end
      endcase
    end else begin
      m_lv = 1'b0;
    end
    if (acc) m_q.push_back(f);
    m_onq = on;
  endfunction

  task automatic check_model();
    chk("ready",  32'(bus.ready_o),      32'(m_q.size() < DEPTH));
    chk("lvalid", 32'(bus.link_valid_o), 32'(m_lv));
    chk("lflit",  32'(bus.link_flit_o),  32'(m_lf));
    chk("err",    32'(err),              32'(m_err));
    chk("sent",   32'(sent),             32'(m_sent));
    chk("stall",  32'(stall),            32'(m_stall));
  endtask

  task automatic cyc(input logic v, input flit_Data_noVC f, input logic on);
    bus.valid_i  = v;
    bus.flit_i   = f;
    bus.on_off_i = on;
    m_step(v, f, on);
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.valid_i = 1'b0; bus.on_off_i = 1'b1; bus.flit_i = '0;
    m_reset();
    #1;
    chk("rst_lvalid", 32'(bus.link_valid_o), 32'd0);
    chk("rst_ready",  32'(bus.ready_o),      32'd1);
    chk("rst_lflit",  32'(bus.link_flit_o),  32'd0);
    chk("rst_err",    32'(err),              32'd0);
    chk("rst_sent",   32'(sent),             32'd0);
    chk("rst_stall",  32'(stall),            32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    flit_label_t lab;
    logic [15:0] d;
    logic        on;
    logic        e_rdy;
    logic        e_lv;
    logic [15:0] e_ld;
  } vec_t;

  vec_t tbl [12];

  initial begin
    flit_Data_noVC pkt [7];
    flit_Data_noVC pend;
    logic pend_v, on, gen_inpkt, acc;
    int idx, rx, off_vld;

    rst_n = 1'b0;
    tbl[0]  = '{1, HEAD,     16'd1, 1, 1, 0, 16'd0};
    tbl[1]  = '{1, BODY,     16'd2, 1, 1, 1, 16'd1};
    tbl[2]  = '{0, HEAD,     16'd0, 1, 1, 1, 16'd2};
    tbl[3]  = '{1, TAIL,     16'd3, 1, 1, 0, 16'd2};
    tbl[4]  = '{0, HEAD,     16'd0, 0, 1, 1, 16'd3};
    tbl[5]  = '{1, HEADTAIL, 16'd4, 0, 1, 0, 16'd3};
    tbl[6]  = '{1, HEADTAIL, 16'd5, 0, 0, 0, 16'd3};
    tbl[7]  = '{1, HEADTAIL, 16'd6, 1, 0, 0, 16'd3};
    tbl[8]  = '{1, HEADTAIL, 16'd6, 1, 1, 1, 16'd4};
    tbl[9]  = '{1, HEADTAIL, 16'd6, 1, 1, 1, 16'd5};
    tbl[10] = '{0, HEAD,     16'd0, 1, 1, 1, 16'd6};
    tbl[11] = '{0, HEAD,     16'd0, 1, 1, 0, 16'd6};

    // Vector table: streaming, OFF backpressure, held flit while not ready.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, mkf(tbl[i].lab, tbl[i].d), tbl[i].on);
      chk($sformatf("tbl%0d_ready", i),  32'(bus.ready_o),           32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_lvalid", i), 32'(bus.link_valid_o),      32'(tbl[i].e_lv));
      chk($sformatf("tbl%0d_ldata", i),  32'(bus.link_flit_o.data),  32'(tbl[i].e_ld));
    end
    chk("tbl_sent",  32'(sent),  32'd6);
    chk("tbl_stall", 32'(stall), 32'd2);
    chk("tbl_err",   32'(err),   32'd0);

    // Single HEADTAIL after idle cycles: exactly one link_valid cycle.
    do_reset();
    repeat (4) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, mkf(HEADTAIL, 16'hA5A5), 1'b1);
    chk("ht_lat_none", 32'(bus.link_valid_o), 32'd0);
    cyc(1'b0, '0, 1'b1);
    chk("ht_lat_one",  32'(bus.link_valid_o), 32'd1);
    cyc(1'b0, '0, 1'b1);
    chk("ht_lat_once", 32'(bus.link_valid_o), 32'd0);
    chk("ht_sent",     32'(sent),             32'd1);

    // OFF mid-packet: bounded in-flight sends, packet completes in order.
    do_reset();
    pkt[0] = mkf(HEAD, 16'h100);
    for (int i = 1; i < 6; i++) pkt[i] = mkf(BODY, 16'(16'h100 + i));
    pkt[6] = mkf(TAIL, 16'h106);
    idx = 0; rx = 0; off_vld = 0;
    for (int k = 0; k < 30; k++) begin
      on  = !(k >= 3 && k < 9);
      acc = (idx < 7) && (m_q.size() < DEPTH);
      cyc(idx < 7, pkt[idx < 7 ? idx : 6], on);
      if (acc) idx++;
      if (bus.link_valid_o) begin
        chk($sformatf("off_order%0d", rx), 32'(bus.link_flit_o), 32'(pkt[rx < 7 ? rx : 6]));
        rx++;
        if (k >= 3 && k < 9) off_vld++;
      end
    end
    chk("off_inflight_le2", 32'(off_vld <= 2), 32'd1);
    chk("off_rx_count",     32'(rx),           32'd7);
    chk("off_err",          32'(err),          32'd0);

    // Framing errors: BODY from idle, then HEAD, HEAD.
    do_reset();
    cyc(1'b1, mkf(BODY, 16'd10), 1'b1);
    cyc(1'b1, mkf(HEAD, 16'd11), 1'b1);
    chk("perr_after_body", 32'(err), 32'd1);
    cyc(1'b1, mkf(HEAD, 16'd12), 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);
    chk("perr_sticky", 32'(err),  32'd1);
    chk("perr_sent",   32'(sent), 32'd3);

    // Random well-formed traffic with on/off bursts; counters saturate.
    do_reset();
    pend_v = 1'b0; pend = '0; on = 1'b1; gen_inpkt = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 7) == 0) on = ~on;
      if (!pend_v && $urandom_range(0, 3) != 0) begin
        if (gen_inpkt) pend = mkf($urandom_range(0, 2) == 0 ? TAIL : BODY, 16'($urandom));
        else           pend = mkf($urandom_range(0, 1) == 0 ? HEAD : HEADTAIL, 16'($urandom));
        pend_v = 1'b1;
      end
      acc = pend_v && (m_q.size() < DEPTH);
      cyc(pend_v, pend, on);
      if (acc) begin
        pend_v = 1'b0;
        if (pend.flit_label == HEAD) gen_inpkt = 1'b1;
        else if (pend.flit_label != BODY) gen_inpkt = 1'b0;
      end
    end
    chk("rnd_sent_sat", 32'(sent), 32'(CMAX));

    // Random labels, including framing violations.
    do_reset();
    pend_v = 1'b0; on = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) on = ~on;
      if (!pend_v && $urandom_range(0, 2) != 0) begin
        pend = mkf(flit_label_t'($urandom_range(0, 3)), 16'($urandom));
        pend_v = 1'b1;
      end
      acc = pend_v && (m_q.size() < DEPTH);
      cyc(pend_v, pend, on);
      if (acc) pend_v = 1'b0;
    end

    // Reset with two flits queued mid-packet: nothing leaks out afterwards.
    do_reset();
    cyc(1'b1, mkf(HEAD, 16'h200), 1'b0);
    cyc(1'b1, mkf(BODY, 16'h201), 1'b0);
    chk("mid_queued_full", 32'(bus.ready_o), 32'd0);
    #2;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, 1'b1);
      chk($sformatf("mid_no_leak%0d", k), 32'(bus.link_valid_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
